// File: rtl/program_loader.sv
// program_loader: boot loader that writes a big-endian byte stream into instruction memory and then releases the core.
// Optional trailing XOR checksum byte enabled by defining PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        im_we,
    output logic [31:0] im_addr,
    output logic [31:0] im_wdata,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);
    typedef enum logic [2:0] {
        LEN_HI, LEN_LO, LOAD, FINISH,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        CHK,
`endif
        RUN, ERROR
    } state_t;

    localparam logic [15:0] MAX_WORDS = 16'(DEPTH);

    state_t      state, state_next;
    logic [7:0]  len_hi;
    logic [15:0] len, k, n;
    logic [1:0]  b;
    logic [23:0] shift;
    logic        fire, last, len_bad;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0] acc;
    assign in_ready = !reset && (state == LEN_HI || state == LEN_LO || state == LOAD || state == CHK);
`else
    assign in_ready = !reset && (state == LEN_HI || state == LEN_LO || state == LOAD);
`endif

    assign fire      = in_valid && in_ready;
    assign n         = {len_hi, in_data};
    assign len_bad   = n == 16'd0 || n > MAX_WORDS;
    assign last      = k == len - 16'd1 && b == 2'd3;
    assign cpu_reset = state != RUN;
    assign done      = state == RUN;
    assign error     = state == ERROR;

    always_ff @(posedge clk) begin
        if (reset) state <= LEN_HI;
        else state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            LEN_HI: if (fire) state_next = LEN_LO;
            LEN_LO: if (fire) state_next = len_bad ? ERROR : LOAD;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            LOAD:   if (fire && last) state_next = CHK;
            CHK:    if (fire) state_next = in_data == acc ? RUN : ERROR;
`else
            LOAD:   if (fire && last) state_next = FINISH;
`endif
            FINISH: state_next = RUN;
            default: state_next = state;
        endcase
    end

    // The write strobe is registered so it lands in the cycle after the 4th byte is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_hi   <= '0;
            len      <= '0;
            k        <= '0;
            b        <= '0;
            shift    <= '0;
            im_we    <= 1'b0;
            im_addr  <= '0;
            im_wdata <= '0;
        end else begin
            im_we <= fire && state == LOAD && b == 2'd3;
            if (fire && state == LEN_HI) len_hi <= in_data;
            if (fire && state == LEN_LO) begin
                len <= n;
                k   <= '0;
                b   <= '0;
            end
            if (fire && state == LOAD) begin
                b     <= b + 2'd1;
                shift <= {shift[15:0], in_data};
                if (b == 2'd3) begin
                    im_wdata <= {shift, in_data};
                    im_addr  <= {14'd0, k, 2'b00};
                    k        <= k + 16'd1;
                end
            end
        end
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset) acc <= '0;
        else if (fire && state == LOAD) acc <= acc ^ in_data;
    end
`endif
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: table, hand-written and random load streams checked against a byte-level stream model.
module tb_program_loader;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, im_we, cpu_reset, done, error;
    logic [31:0] im_addr, im_wdata;

    program_loader #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .cpu_reset(cpu_reset), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_we = -1;
    int rel_cyc = -1;
    logic prev_cr = 1'b1;
    logic [31:0] got_a[$];
    logic [31:0] got_d[$];
    logic [31:0] exp_a[$];
    logic [31:0] exp_d[$];
    logic [7:0]  stream[$];
    int exp_st;
    int base;

    always @(negedge clk) begin
        cyc++;
        if (im_we) begin
            got_a.push_back(im_addr);
            got_d.push_back(im_wdata);
            last_we = cyc;
        end
        if (!cpu_reset && prev_cr) rel_cyc = cyc;
        prev_cr = cpu_reset;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Expected result of a whole stream: 0 = still loading, 1 = running, 2 = rejected.
    task automatic model();
        int n;
        logic [7:0] x;
        exp_a.delete();
        exp_d.delete();
        x = 8'h00;
        n = int'({stream[0], stream[1]});
        if (n == 0 || n > DEPTH) begin
            exp_st = 2;
            return;
        end
        for (int i = 0; i < n; i++) begin
            exp_a.push_back(32'(i * 4));
            exp_d.push_back({stream[2+4*i], stream[3+4*i], stream[4+4*i], stream[5+4*i]});
            x = x ^ stream[2+4*i] ^ stream[3+4*i] ^ stream[4+4*i] ^ stream[5+4*i];
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        exp_st = stream.size() <= 2 + 4 * n ? 0 : (stream[2+4*n] == x ? 1 : 2);
`else
        exp_st = 1;
`endif
    endtask

    task automatic do_reset(input bit check);
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        if (check) begin
            chk("rst_in_ready", 32'(in_ready), 32'd0);
            chk("rst_im_we", 32'(im_we), 32'd0);
            chk("rst_im_addr", im_addr, 32'd0);
            chk("rst_im_wdata", im_wdata, 32'd0);
            chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_error", 32'(error), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input int gap);
        int t;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data = d;
        t = 0;
        #1;
        while (!in_ready && t < 10) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("byte_accepted", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run(input int gap, input bit rnd_gap);
        do_reset(0);
        base = got_a.size();
        foreach (stream[i]) send(stream[i], rnd_gap ? int'($urandom_range(0, 2)) : gap);
        repeat (3) @(negedge clk);
        #1;
        model();
        chk("error", 32'(error), 32'(exp_st == 2));
        chk("done", 32'(done), 32'(exp_st == 1));
        chk("cpu_reset", 32'(cpu_reset), 32'(exp_st != 1));
        chk("n_writes", 32'(got_a.size() - base), 32'(exp_a.size()));
        for (int i = 0; i < exp_a.size() && base + i < got_a.size(); i++) begin
            chk("wr_addr", got_a[base+i], exp_a[i]);
            chk("wr_data", got_d[base+i], exp_d[i]);
        end
    endtask

    // Bytes offered in a terminal state must be refused and must not write memory.
    task automatic poke();
        int cnt, b0;
        b0 = got_a.size();
        cnt = 0;
        in_valid = 1'b1;
        in_data = 8'hFF;
        repeat (10) begin
            @(negedge clk);
            #1;
            if (in_ready) cnt++;
        end
        in_valid = 1'b0;
        chk("term_in_ready", 32'(cnt), 32'd0);
        chk("term_writes", 32'(got_a.size() - b0), 32'd0);
        chk("term_done", 32'(done), 32'(exp_st == 1));
        chk("term_error", 32'(error), 32'(exp_st == 2));
    endtask

    typedef struct {
        logic [15:0] n;
        int          gap;
        logic        exp_err;
        logic        exp_done;
    } vec_t;

    initial begin
        vec_t vt[7];
        logic [7:0] x, v;
        int nw;
        vt = '{'{16'd0, 0, 1'b1, 1'b0}, '{16'd1, 0, 1'b0, 1'b1}, '{16'd2, 1, 1'b0, 1'b1},
               '{16'd64, 0, 1'b0, 1'b1}, '{16'd65, 0, 1'b1, 1'b0}, '{16'h0100, 0, 1'b1, 1'b0},
               '{16'hFFFF, 2, 1'b1, 1'b0}};

        do_reset(1);

        stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h04};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        stream.push_back(8'h8D);
`endif
        run(0, 0);
        chk("basic_n", 32'(got_a.size() - base), 32'd2);
        if (got_a.size() >= base + 2) begin
            chk("basic_a0", got_a[base], 32'h0);
            chk("basic_d0", got_d[base], 32'h20080005);
            chk("basic_a1", got_a[base+1], 32'h4);
            chk("basic_d1", got_d[base+1], 32'hAC080004);
        end
        chk("release_latency", 32'(rel_cyc - last_we), 32'd1);
        poke();

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        stream[10] = 8'h8C;
        run(0, 0);
        chk("bad_sum_error", 32'(error), 32'd1);
        chk("bad_sum_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("bad_sum_n", 32'(got_a.size() - base), 32'd2);
        poke();
        stream[10] = 8'h8D;
`endif

        run(3, 0);
        chk("gap_n", 32'(got_a.size() - base), 32'd2);
        if (got_a.size() >= base + 2) chk("gap_d1", got_d[base+1], 32'hAC080004);

        do_reset(0);
        base = got_a.size();
        for (int i = 0; i < 5; i++) send(stream[i], 0);
        repeat (2) @(negedge clk);
        chk("partial_no_write", 32'(got_a.size() - base), 32'd0);
        do_reset(1);
        repeat (2) @(negedge clk);
        chk("reset_no_spurious", 32'(got_a.size() - base), 32'd0);
        run(0, 0);
        chk("replay_n", 32'(got_a.size() - base), 32'd2);

        for (int t = 0; t < 7; t++) begin
            stream.delete();
            stream.push_back(vt[t].n[15:8]);
            stream.push_back(vt[t].n[7:0]);
            x = 8'h00;
            if (!vt[t].exp_err) begin
                for (int i = 0; i < 4 * int'(vt[t].n); i++) begin
                    v = 8'($urandom);
                    x ^= v;
                    stream.push_back(v);
                end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                stream.push_back(x);
`endif
            end
            run(vt[t].gap, 0);
            chk("tbl_error", 32'(error), 32'(vt[t].exp_err));
            chk("tbl_done", 32'(done), 32'(vt[t].exp_done));
            poke();
        end

        for (int r = 0; r < 6; r++) begin
            nw = int'($urandom_range(1, DEPTH));
            stream.delete();
            stream.push_back(8'(nw >> 8));
            stream.push_back(8'(nw));
            x = 8'h00;
            for (int i = 0; i < 4 * nw; i++) begin
                v = 8'($urandom);
                x ^= v;
                stream.push_back(v);
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            stream.push_back($urandom_range(0, 1) == 0 ? x : x ^ 8'(1 << $urandom_range(0, 7)));
`endif
            run(0, 1);
            poke();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
